// File: rtl/bpsk_pkg.sv
// Shared BPSK definitions: FSM states, NCO reset defaults and datapath widths.
// The receiver-side NCO programming takes its defaults from here as well.
package bpsk_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } bpsk_state_e;

  localparam logic [31:0] FREQ_RST_DEF  = 32'h2000_0000;
  localparam logic [31:0] PHASE_RST_DEF = 32'hC000_0000;
  localparam int          LUT_AW        = 8;
  localparam int          SAMPLE_W      = 8;

endpackage

// File: rtl/bpsk_sine_rom.sv
// 256-entry signed sine ROM (amplitude 127) with one registered read cycle.
// Stores only the first quarter wave and folds the address to cover the rest.
module bpsk_sine_rom
  import bpsk_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [LUT_AW-1:0]          addr,
  output logic signed [SAMPLE_W-1:0] data
);

  function automatic logic [6:0] quarter_sine(input logic [6:0] idx);
    logic [6:0] q;
    case (idx)
      7'd0:  q = 7'd0;   7'd1:  q = 7'd3;   7'd2:  q = 7'd6;   7'd3:  q = 7'd9;
      7'd4:  q = 7'd12;  7'd5:  q = 7'd16;  7'd6:  q = 7'd19;  7'd7:  q = 7'd22;
      7'd8:  q = 7'd25;  7'd9:  q = 7'd28;  7'd10: q = 7'd31;  7'd11: q = 7'd34;
      7'd12: q = 7'd37;  7'd13: q = 7'd40;  7'd14: q = 7'd43;  7'd15: q = 7'd46;
      7'd16: q = 7'd49;  7'd17: q = 7'd51;  7'd18: q = 7'd54;  7'd19: q = 7'd57;
      7'd20: q = 7'd60;  7'd21: q = 7'd63;  7'd22: q = 7'd65;  7'd23: q = 7'd68;
      7'd24: q = 7'd71;  7'd25: q = 7'd73;  7'd26: q = 7'd76;  7'd27: q = 7'd78;
      7'd28: q = 7'd81;  7'd29: q = 7'd83;  7'd30: q = 7'd85;  7'd31: q = 7'd88;
      7'd32: q = 7'd90;  7'd33: q = 7'd92;  7'd34: q = 7'd94;  7'd35: q = 7'd96;
      7'd36: q = 7'd98;  7'd37: q = 7'd100; 7'd38: q = 7'd102; 7'd39: q = 7'd104;
      7'd40: q = 7'd106; 7'd41: q = 7'd107; 7'd42: q = 7'd109; 7'd43: q = 7'd111;
      7'd44: q = 7'd112; 7'd45: q = 7'd113; 7'd46: q = 7'd115; 7'd47: q = 7'd116;
      7'd48: q = 7'd117; 7'd49: q = 7'd118; 7'd50: q = 7'd120; 7'd51: q = 7'd121;
      7'd52: q = 7'd122; 7'd53: q = 7'd122; 7'd54: q = 7'd123; 7'd55: q = 7'd124;
      7'd56: q = 7'd125; 7'd57: q = 7'd125; 7'd58: q = 7'd126; 7'd59: q = 7'd126;
      7'd60: q = 7'd126; 7'd61: q = 7'd127; 7'd62: q = 7'd127; 7'd63: q = 7'd127;
      7'd64: q = 7'd127;
      default: q = 7'd0;
    endcase
    return q;
  endfunction

  logic [6:0]                 idx_s;
  logic signed [SAMPLE_W-1:0] mag_s;
  logic signed [SAMPLE_W-1:0] val_s;

  // Quarter-wave fold: mirror the index in quadrants 1/3, negate in quadrants 2/3.
  always_comb begin
    idx_s = 7'd0;
    mag_s = {SAMPLE_W{1'b0}};
    val_s = {SAMPLE_W{1'b0}};
    if (addr[6]) begin
      idx_s = 7'd64 - {1'b0, addr[5:0]};
    end else begin
      idx_s = {1'b0, addr[5:0]};
    end
    mag_s = {1'b0, quarter_sine(idx_s)};
    if (addr[7]) begin
      val_s = -mag_s;
    end else begin
      val_s = mag_s;
    end
  end

  // Registered ROM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= {SAMPLE_W{1'b0}};
    end else begin
      data <= val_s;
    end
  end

endmodule

// File: rtl/bpsk_tx.sv
// BPSK transmitter: bit handshake, NCO phase accumulator, sine ROM and sign modulation.
// Define BPSK_TX_DIFF_EN to transmit differentially encoded symbols (DBPSK).
module bpsk_tx
  import bpsk_pkg::*;
#(
  parameter int          SPS       = 16,
  parameter logic [31:0] FREQ_RST  = FREQ_RST_DEF,
  parameter logic [31:0] PHASE_RST = PHASE_RST_DEF
)(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic                cfg_sel,
  input  logic [31:0]         cfg_data,
  input  logic                bit_valid,
  input  logic                bit_data,
  output logic                bit_ready,
  output logic                tx_valid,
  output logic [SAMPLE_W-1:0] tx_data,
  output logic                tx_sym_start,
  output logic                underrun
);

  localparam logic [7:0] LAST = 8'(SPS - 1);

  bpsk_state_e                state_r, state_s;
  logic [7:0]                 count_r, count_s;
  logic [31:0]                acc_r, acc_s, freq_r, phase_r;
  logic                       sym_r, sym_s, new_sym_s;
  logic                       bit_ready_r, bit_ready_s, underrun_r, underrun_s;
  logic                       accept_s, last_s;
  logic [LUT_AW-1:0]          addr_s;
  logic signed [SAMPLE_W-1:0] rom_data_s, tx_data_r;
  logic                       v1_r, sym1_r, start1_r, tx_valid_r, tx_sym_start_r;

  assign accept_s = bit_valid & bit_ready_r;
  assign last_s   = (count_r == LAST);
  assign addr_s   = LUT_AW'((acc_r + phase_r) >> 5'd24);

`ifdef BPSK_TX_DIFF_EN
  // sym_r is forced to 0 on every IDLE entry, so the first symbol is the raw bit.
  assign new_sym_s = bit_data ^ sym_r;
`else
  assign new_sym_s = bit_data;
`endif

  // Next-state logic for the symbol FSM, sample counter and phase accumulator.
  always_comb begin
    state_s     = state_r;
    count_s     = count_r;
    acc_s       = acc_r;
    sym_s       = sym_r;
    underrun_s  = 1'b0;
    bit_ready_s = 1'b0;
    case (state_r)
      IDLE: begin
        acc_s   = 32'd0;
        count_s = 8'd0;
        if (accept_s) begin
          state_s = RUN;
          sym_s   = new_sym_s;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        acc_s = acc_r + freq_r;
        if (last_s) begin
          count_s = 8'd0;
          if (accept_s) begin
            sym_s = new_sym_s;
          end else begin
            state_s    = IDLE;
            underrun_s = 1'b1;
            sym_s      = 1'b0;
            acc_s      = 32'd0;
          end
        end else begin
          count_s = count_r + 8'd1;
        end
      end
      default: begin
        state_s = IDLE;
        acc_s   = 32'd0;
        count_s = 8'd0;
        sym_s   = 1'b0;
      end
    endcase
    if (state_s == IDLE) begin
      bit_ready_s = 1'b1;
    end else begin
      bit_ready_s = (count_s == LAST);
    end
  end

  // FSM, counter, accumulator and handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      count_r     <= 8'd0;
      acc_r       <= 32'd0;
      sym_r       <= 1'b0;
      bit_ready_r <= 1'b0;
      underrun_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      count_r     <= count_s;
      acc_r       <= acc_s;
      sym_r       <= sym_s;
      bit_ready_r <= bit_ready_s;
      underrun_r  <= underrun_s;
    end
  end

  // Carrier configuration, writable only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_r  <= FREQ_RST;
      phase_r <= PHASE_RST;
    end else if (cfg_we && (state_r == IDLE)) begin
      if (cfg_sel) begin
        phase_r <= cfg_data;
      end else begin
        freq_r <= cfg_data;
      end
    end
  end

  bpsk_sine_rom u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr_s),
    .data  (rom_data_s)
  );

  // Two-stage sample pipeline: align sample tags with the ROM, then apply the symbol sign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r           <= 1'b0;
      sym1_r         <= 1'b0;
      start1_r       <= 1'b0;
      tx_valid_r     <= 1'b0;
      tx_sym_start_r <= 1'b0;
      tx_data_r      <= {SAMPLE_W{1'b0}};
    end else begin
      v1_r           <= (state_r == RUN);
      sym1_r         <= sym_r;
      start1_r       <= (state_r == RUN) && (count_r == 8'd0);
      tx_valid_r     <= v1_r;
      tx_sym_start_r <= v1_r && start1_r;
      if (v1_r) begin
        tx_data_r <= sym1_r ? rom_data_s : -rom_data_s;
      end else begin
        tx_data_r <= {SAMPLE_W{1'b0}};
      end
    end
  end

  assign bit_ready    = bit_ready_r;
  assign underrun     = underrun_r;
  assign tx_valid     = tx_valid_r;
  assign tx_data      = tx_data_r;
  assign tx_sym_start = tx_sym_start_r;

endmodule

// File: tb/tb_bpsk_tx.sv
// Self-checking bench for bpsk_tx: directed scenarios plus random traffic against a
// sample-index based reference model (expected samples from $sin of the carrier phase).
module tb_bpsk_tx;
  import bpsk_pkg::*;

  localparam int  SPS = 8;
  localparam real PI  = 3.14159265358979;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we = 1'b0, cfg_sel = 1'b0;
  logic [31:0] cfg_data = 32'd0;
  logic        bit_valid = 1'b0, bit_data = 1'b0;
  logic        bit_ready, tx_valid, tx_sym_start, underrun;
  logic [7:0]  tx_data;

  always #5 clk = ~clk;

  bpsk_tx #(.SPS(SPS)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(bit_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_sym_start(tx_sym_start), .underrun(underrun)
  );

  int n_vec = 0, n_err = 0;
  int log_q[$];

  // Reference model state: running flag, sample index since start of run, current symbol.
  bit          m_run, m_sym, m_ready, m_acc;
  int          m_k;
  logic [31:0] m_freq, m_phase;
  bit          d1_v, d1_st, e_v, e_st, e_un;
  int          d1_d, e_d;

  task automatic check_val(input string tag, input int obs, input int exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int lut_ref(input int a);
    real r;
    r = 127.0 * $sin(2.0 * PI * a / 256.0);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction

  task automatic model_reset();
    m_run = 0; m_sym = 0; m_ready = 0; m_acc = 0; m_k = 0;
    m_freq = FREQ_RST_DEF; m_phase = PHASE_RST_DEF;
    d1_v = 0; d1_st = 0; d1_d = 0; e_v = 0; e_st = 0; e_d = 0; e_un = 0;
  endtask

  task automatic model_step(input bit bv, input bit bd, input bit we, input bit sel,
                            input logic [31:0] data);
    logic [31:0] ph;
    bit last;
    int s_d;
    m_acc = m_ready && bv;
    s_d = 0;
    if (m_run) begin
      ph  = 32'(m_k) * m_freq + m_phase;
      s_d = m_sym ? lut_ref(int'(ph[31:24])) : -lut_ref(int'(ph[31:24]));
    end
    e_v = d1_v; e_d = d1_d; e_st = d1_st;
    d1_v = m_run; d1_d = s_d; d1_st = m_run && (m_k % SPS == 0);
    e_un = 0;
    if (!m_run) begin
      if (we) begin
        if (sel) m_phase = data;
        else     m_freq  = data;
      end
      if (m_acc) begin
        m_run = 1; m_k = 0; m_sym = bd;
      end
    end else begin
      last = (m_k % SPS == SPS - 1);
      if (m_acc) begin
        m_k++;
`ifdef BPSK_TX_DIFF_EN
        m_sym = bd ^ m_sym;
`else
        m_sym = bd;
`endif
      end else if (last) begin
        m_run = 0; e_un = 1;
      end else begin
        m_k++;
      end
    end
    m_ready = !m_run || (m_k % SPS == SPS - 1);
  endtask

  task automatic check_outputs();
    check_val("tx_valid", int'(tx_valid), int'(e_v));
    check_val("tx_data", int'($signed(tx_data)), e_d);
    check_val("tx_sym_start", int'(tx_sym_start), int'(e_st));
    check_val("underrun", int'(underrun), int'(e_un));
    check_val("bit_ready", int'(bit_ready), int'(m_ready));
    if (tx_valid) log_q.push_back(int'($signed(tx_data)));
  endtask

  task automatic cycle(input bit bv, input bit bd, input bit we, input bit sel,
                       input logic [31:0] data);
    bit_valid = bv; bit_data = bd; cfg_we = we; cfg_sel = sel; cfg_data = data;
    model_step(bv, bd, we, sel, data);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic send_bit(input bit b);
    int n;
    n = 0;
    do begin
      cycle(1'b1, b, 1'b0, 1'b0, 32'd0);
      n++;
    end while (!m_acc && n < 64);
    if (!m_acc) check_val("accept_timeout", 0, 1);
  endtask

  task automatic check_log(input string tag, input int idx, input int exp_v);
    if (idx < log_q.size()) check_val(tag, log_q[idx], exp_v);
    else                    check_val(tag, -999, exp_v);
  endtask

  int exp1[8] = '{-127, -90, 0, 90, 127, 90, 0, -90};
  int exp4[8] = '{0, 127, 0, -127, 0, 127, 0, -127};

  initial begin
    model_reset();
    @(negedge clk);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Single bit 1 with default carrier.
    log_q.delete();
    send_bit(1'b1);
    idle(SPS + 4);
    check_val("t1_count", log_q.size(), 8);
    for (int i = 0; i < 8; i++) check_log("t1_sample", i, exp1[i]);

    // Single bit 0: same waveform negated.
    log_q.delete();
    send_bit(1'b0);
    idle(SPS + 4);
    check_val("t2_count", log_q.size(), 8);
    for (int i = 0; i < 8; i++) check_log("t2_sample", i, -exp1[i]);

    // Back-to-back bits 1,1,0: gapless, phase-continuous.
    log_q.delete();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    idle(SPS + 4);
    check_val("t3_count", log_q.size(), 24);
    check_log("t3_sym0", 4, 127);
`ifdef BPSK_TX_DIFF_EN
    check_log("t3_sym1", 12, -127);
`else
    check_log("t3_sym1", 12, 127);
`endif
    check_log("t3_sym2", 20, -127);

    // Reconfigure carrier in IDLE, then attempt a write during RUN.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h4000_0000);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0000);
    log_q.delete();
    send_bit(1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h1000_0000);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0000);
    idle(SPS + 4);
    check_val("t4_count", log_q.size(), 8);
    for (int i = 0; i < 8; i++) check_log("t4_sample", i, exp4[i]);

    // Asynchronous reset in the middle of a symbol.
    send_bit(1'b1);
    idle(3);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_tx_valid", int'(tx_valid), 0);
    check_val("rst_tx_data", int'(tx_data), 0);
    check_val("rst_sym_start", int'(tx_sym_start), 0);
    check_val("rst_underrun", int'(underrun), 0);
    check_val("rst_bit_ready", int'(bit_ready), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    idle(1);
    log_q.delete();
    send_bit(1'b1);
    idle(SPS + 4);
    check_val("t5_count", log_q.size(), 8);
    check_log("t5_first", 0, -127);

    // Three consecutive ones: sign pattern depends on differential encoding.
    log_q.delete();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    idle(SPS + 4);
    check_log("t6_sym0", 4, 127);
`ifdef BPSK_TX_DIFF_EN
    check_log("t6_sym1", 12, -127);
`else
    check_log("t6_sym1", 12, 127);
`endif
    check_log("t6_sym2", 20, 127);

    // Random traffic, including config writes at arbitrary times.
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)), 32'($urandom));
    end
    idle(SPS + 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
